// File: rtl/ahb_dmac_bus_arbiter_if.sv
// Request/grant bundle between the CPU/DMAC masters and the AHB bus arbiter.
// The arbiter takes the slave modport; the request side takes the master modport.
interface ahb_dmac_bus_arbiter_if;
  logic       Cpu_Req;
  logic       Cpu_Lock;
  logic       Bus_Req;
  logic       HReady;
  logic [1:0] HTrans;
  logic       Cpu_Grant;
  logic       Bus_Grant;
  logic       HMaster;
  logic       Tenure_Expired;

  modport slave (
    input  Cpu_Req,
    input  Cpu_Lock,
    input  Bus_Req,
    input  HReady,
    input  HTrans,
    output Cpu_Grant,
    output Bus_Grant,
    output HMaster,
    output Tenure_Expired
  );

  modport master (
    output Cpu_Req,
    output Cpu_Lock,
    output Bus_Req,
    output HReady,
    output HTrans,
    input  Cpu_Grant,
    input  Bus_Grant,
    input  HMaster,
    input  Tenure_Expired
  );
endinterface

// File: rtl/ahb_dmac_bus_arbiter.sv
// Two-master AHB arbiter (CPU default, DMAC on request) with bounded DMAC tenure
// while the CPU waits, and a guaranteed CPU slot after a forced revocation.
module ahb_dmac_bus_arbiter #(
  parameter int unsigned MAX_TENURE = 16,
  parameter int unsigned CPU_SLOT   = 4
) (
  input  logic                         clk,
  input  logic                         rst,
  ahb_dmac_bus_arbiter_if.slave        bus
);

  localparam int unsigned TenureW = (MAX_TENURE > 0) ? $clog2(MAX_TENURE + 1) : 1;
  localparam int unsigned SlotW   = (CPU_SLOT > 0) ? $clog2(CPU_SLOT + 1) : 1;
  localparam logic [TenureW-1:0] TenureMax = TenureW'(MAX_TENURE);
  localparam logic [SlotW-1:0]   SlotInit  = SlotW'(CPU_SLOT);
  localparam bit                 TenureOn  = (MAX_TENURE != 0);
  localparam logic [1:0]         HTransIdle   = 2'b00;
  localparam logic [1:0]         HTransNonseq = 2'b10;

  typedef enum logic [0:0] {StCpuOwn, StDmacOwn} state_e;

  state_e               state_q, state_d;
  logic [TenureW-1:0]   tenure_q, tenure_d;
  logic [SlotW-1:0]     slot_q, slot_d;
  logic                 hmaster_q, hmaster_d;
  logic                 expired_q, expired_d;
  logic                 hp;
  logic                 revoke;

  // Only switch owners on a completed beat that starts a new transfer, never mid-burst.
  assign hp = bus.HReady & ((bus.HTrans == HTransIdle) | (bus.HTrans == HTransNonseq));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= StCpuOwn;
      tenure_q  <= '0;
      slot_q    <= '0;
      hmaster_q <= 1'b0;
      expired_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      tenure_q  <= tenure_d;
      slot_q    <= slot_d;
      hmaster_q <= hmaster_d;
      expired_q <= expired_d;
    end
  end

  always_comb begin
    state_d = state_q;
    revoke  = 1'b0;
    unique case (state_q)
      StCpuOwn: begin
        if (hp && bus.Bus_Req && !bus.Cpu_Lock && (slot_q == '0)) state_d = StDmacOwn;
      end
      StDmacOwn: begin
        // A falling Bus_Req wins over a simultaneous revocation: plain release, no pulse.
        if (!bus.Bus_Req && hp) begin
          state_d = StCpuOwn;
        end else if (TenureOn && bus.Cpu_Req && (tenure_q == TenureMax) && hp) begin
          state_d = StCpuOwn;
          revoke  = 1'b1;
        end
      end
      default: state_d = StCpuOwn;
    endcase
  end

  always_comb begin
    tenure_d  = tenure_q;
    slot_d    = slot_q;
    expired_d = revoke;
    hmaster_d = bus.HReady ? (state_q == StDmacOwn) : hmaster_q;
    if (state_q == StCpuOwn) begin
      if (state_d == StDmacOwn) begin
        tenure_d = '0;
      end else if (!bus.Cpu_Req) begin
        slot_d = '0;
      end else if (bus.HReady && (slot_q != '0)) begin
        slot_d = slot_q - SlotW'(1);
      end
    end else begin
      if (revoke) begin
        slot_d = SlotInit;
      end else if (state_d == StCpuOwn) begin
        slot_d = '0;
      end else if (!bus.Cpu_Req) begin
        tenure_d = '0;
      end else if (bus.HReady && (tenure_q != TenureMax)) begin
        tenure_d = tenure_q + TenureW'(1);
      end
    end
  end

  assign bus.Bus_Grant      = (state_q == StDmacOwn);
  assign bus.Cpu_Grant      = (state_q == StCpuOwn);
  assign bus.HMaster        = hmaster_q;
  assign bus.Tenure_Expired = expired_q;

endmodule
